coin_acceptor: RTL and testbench

Front-end stage for `vending_machine`. It takes two raw, asynchronous, bouncy coin-sensor lines and produces the clean 2-bit coin code `x` that `vending_machine` consumes. Each physical coin insertion yields exactly one single-cycle code (2'b01 for the low-value coin, 2'b10 for the high-value coin). Codes are always separated by at least one 2'b00 cycle, and a stuck sensor is flagged as jammed instead of being counted.

---
 rtl/coin_acceptor.sv | 138 +++++++++++++
 tb/tb_coin_acceptor.sv | 138 +++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced, jam-aware two-channel coin sensor front end
// Produces one single-cycle coin code per insertion, with a 2'b00 gap cycle between codes.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned JAM_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_a_raw,
    input  logic       coin_b_raw,
    output logic [1:0] x,
    output logic       jam_a,
    output logic       jam_b
);

    typedef enum logic [2:0] {
        ARM  = 3'd0,
        IDLE = 3'd1,
        RISE = 3'd2,
        HELD = 3'd3,
        JAM  = 3'd4
    } state_t;

    localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE);
    localparam logic [7:0] JAM_LIM = 8'(JAM_CYCLES);

    // Index 0 is channel A, index 1 is channel B throughout.
    logic [1:0] raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    state_t     state_q [2];
    logic [7:0] cnt_q   [2];
    logic [7:0] cnt_inc [2];
    logic [1:0] pend_q;
    logic [1:0] jam_q;
    logic [1:0] x_q;
    logic [1:0] x_d;

    assign raw = {coin_b_raw, coin_a_raw};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_inc[i] = cnt_q[i] + 8'd1;
        end
    end

    // x_d doubles as the grant vector: bit i set means channel i's pend is consumed.
    always_comb begin
        x_d = 2'b00;
        if (x_q == 2'b00) begin
            if (pend_q[0]) begin
                x_d = 2'b01;
            end else if (pend_q[1]) begin
                x_d = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            pend_q  <= 2'b00;
            jam_q   <= 2'b00;
            x_q     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ARM;
                cnt_q[i]   <= 8'd0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            x_q     <= x_d;
            for (int i = 0; i < 2; i++) begin
                pend_q[i] <= pend_q[i] & ~x_d[i];
                case (state_q[i])
                    ARM: begin
                        if (sync2_q[i]) begin
                            cnt_q[i] <= 8'd0;
                        end else if (cnt_inc[i] == DEB_LIM) begin
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= 8'd0;
                        end else begin
                            cnt_q[i] <= cnt_inc[i];
                        end
                    end
                    IDLE: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= RISE;
                            cnt_q[i]   <= 8'd1;
                        end
                    end
                    RISE: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= 8'd0;
                        end else if (cnt_inc[i] == DEB_LIM) begin
                            state_q[i] <= HELD;
                            cnt_q[i]   <= 8'd0;
                            pend_q[i]  <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_inc[i];
                        end
                    end
                    HELD: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= ARM;
                            cnt_q[i]   <= 8'd1;
                        end else if (cnt_inc[i] == JAM_LIM) begin
                            state_q[i] <= JAM;
                            cnt_q[i]   <= 8'd0;
                            jam_q[i]   <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_inc[i];
                        end
                    end
                    JAM: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= ARM;
                            cnt_q[i]   <= 8'd1;
                            jam_q[i]   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q[i] <= ARM;
                        cnt_q[i]   <= 8'd0;
                        jam_q[i]   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign x     = x_q;
    assign jam_a = jam_q[0];
    assign jam_b = jam_q[1];

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - scoreboard bench for coin_acceptor
module tb_coin_acceptor;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       coin_a_raw = 1'b0;
    logic       coin_b_raw = 1'b0;
    logic [1:0] x;
    logic       jam_a;
    logic       jam_b;

    coin_acceptor #(.DEBOUNCE(4), .JAM_CYCLES(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_a_raw (coin_a_raw),
        .coin_b_raw (coin_b_raw),
        .x          (x),
        .jam_a      (jam_a),
        .jam_b      (jam_b)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        logic [1:0] code;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   e0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
    endtask

    task automatic push(input logic [1:0] code, input int at);
        exp_t e;
        e.code = code;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every non-zero code on x must match the oldest expectation, both in value and edge.
    always @(negedge clk) begin
        exp_t e;
        if (x != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_x", int'(x), 0);
            end else begin
                e = sb.pop_front();
                check("x_code", int'(x), int'(e.code));
                check("x_edge", edge_n, e.at);
            end
        end
    end

    initial begin
        rst = 1'b1;
        tick(3);
        check("reset_x", int'(x), 0);
        check("reset_jam_a", int'(jam_a), 0);
        check("reset_jam_b", int'(jam_b), 0);
        rst = 1'b0;
        tick(10);

        // clean A held 8 samples
        coin_a_raw = 1'b1; e0 = edge_n + 1; push(2'b01, e0 + 6);
        tick(8); coin_a_raw = 1'b0;
        check("clean_a_jam", int'(jam_a), 0);
        tick(12);

        // bouncy B: two short bursts rejected, then a long one
        coin_b_raw = 1'b1; tick(2); coin_b_raw = 1'b0; tick(1);
        coin_b_raw = 1'b1; tick(2); coin_b_raw = 1'b0; tick(1);
        coin_b_raw = 1'b1; e0 = edge_n + 1; push(2'b10, e0 + 6);
        tick(10); coin_b_raw = 1'b0;
        tick(12);

        // simultaneous qualification: 01, 00, 10
        coin_a_raw = 1'b1; coin_b_raw = 1'b1; e0 = edge_n + 1;
        push(2'b01, e0 + 6); push(2'b10, e0 + 8);
        tick(8); coin_a_raw = 1'b0; coin_b_raw = 1'b0;
        tick(12);

        // B then A one edge later: A waits out the gap cycle
        coin_b_raw = 1'b1; e0 = edge_n + 1; push(2'b10, e0 + 6);
        tick(1); coin_a_raw = 1'b1; push(2'b01, e0 + 8);
        tick(8); coin_b_raw = 1'b0; tick(1); coin_a_raw = 1'b0;
        tick(12);

        // A stuck high 80 samples
        coin_a_raw = 1'b1; e0 = edge_n + 1; push(2'b01, e0 + 6);
        tick(69); check("jam_a_before", int'(jam_a), 0);
        tick(1);  check("jam_a_rise", int'(jam_a), 1);
        tick(10); coin_a_raw = 1'b0;
        tick(2);  check("jam_a_hold", int'(jam_a), 1);
        tick(1);  check("jam_a_fall", int'(jam_a), 0);
        tick(12);

        // B held through reset is never counted
        coin_b_raw = 1'b1; tick(3);
        rst = 1'b1; tick(3);
        check("rst_mid_x", int'(x), 0);
        check("rst_mid_jam_b", int'(jam_b), 0);
        rst = 1'b0; tick(20); coin_b_raw = 1'b0; tick(12);
        coin_b_raw = 1'b1; e0 = edge_n + 1; push(2'b10, e0 + 6);
        tick(8); coin_b_raw = 1'b0;
        check("post_rst_b_jam", int'(jam_b), 0);
        tick(12);

        // reset lands on the edge that would have issued pend_a
        coin_a_raw = 1'b1; e0 = edge_n + 1;
        tick(6);
        rst = 1'b1; coin_a_raw = 1'b0;
        tick(2); check("rst_pend_x", int'(x), 0);
        rst = 1'b0; tick(12);
        check("rst_pend_jam_a", int'(jam_a), 0);
        coin_a_raw = 1'b1; e0 = edge_n + 1; push(2'b01, e0 + 6);
        tick(8); coin_a_raw = 1'b0;
        tick(12);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
